// File: rtl/soustracteur_serie_8bit.sv
// Bit-serial 8-bit subtractor: s = a - b - rin, one bit per clock, LSB first.
// A single borrow flip-flop carries the borrow between bits. Results (s, rout,
// ovf) are registered and only change when the DONE state is entered or on reset.
//
// Handshake: start is sampled on a rising edge while the block is in IDLE or DONE.
// When it is accepted, busy is high for the next 8 cycles. done is then high for
// exactly one cycle, and s/rout/ovf are valid from that cycle on. While busy is
// high, start, a, b and rin are ignored.
module soustracteur_serie_8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       rin,
    output logic [7:0] s,
    output logic       rout,
    output logic       ovf,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPUTE = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    logic [1:0] state;
    logic [7:0] sh_a;
    logic [7:0] sh_b;
    logic [7:0] res;
    logic       br;
    logic [2:0] cnt;
    logic       a7;
    logic       b7;

    logic       ai;
    logic       bi;
    logic       d;
    logic       br_next;
    logic [7:0] res_next;

    // One full-subtractor bit slice on the current LSBs of the operand shift registers
    always_comb begin
        ai       = sh_a[0];
        bi       = sh_b[0];
        d        = ai ^ bi ^ br;
        br_next  = (~ai & bi) | (~(ai ^ bi) & br);
        res_next = {d, res[7:1]};
    end

    // FSM, operand shifting, borrow chain and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sh_a  <= 8'd0;
            sh_b  <= 8'd0;
            res   <= 8'd0;
            br    <= 1'b0;
            cnt   <= 3'd0;
            a7    <= 1'b0;
            b7    <= 1'b0;
            s     <= 8'd0;
            rout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        br    <= rin;
                        // Sign bits are kept aside because the shift registers lose them
                        a7    <= a[7];
                        b7    <= b[7];
                        cnt   <= 3'd0;
                        state <= COMPUTE;
                    end else begin
                        state <= IDLE;
                    end
                end
                COMPUTE: begin
                    sh_a <= sh_a >> 1;
                    sh_b <= sh_b >> 1;
                    br   <= br_next;
                    res  <= res_next;
                    cnt  <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state <= DONE;
                        s     <= res_next;
                        rout  <= br_next;
                        ovf   <= (a7 ^ b7) & (res_next[7] ^ a7);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == COMPUTE);
    assign done = (state == DONE);

endmodule

// File: doc/soustracteur_serie_8bit.md
SOUSTRACTEUR_SERIE_8BIT -- requirements
Module: soustracteur_serie_8bit

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Ports SHALL be exactly as follows:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request a new subtraction; sampled on rising edge.
- a  input  8  minuend, unsigned.
- b  input  8  subtrahend, unsigned.
- rin  input  1  borrow in.
- s  output  8  difference (a - b - rin) mod 256; registered.
- rout  output  1  borrow out; 1 iff a < b + rin; registered.
- ovf  output  1  two's-complement overflow; registered.
- busy  output  1  high while in COMPUTE.
- done  output  1  one-cycle pulse when s/rout/ovf become valid.
REQ-003 The block SHALL have no parameters; width is fixed at 8.

Function
REQ-004 Architecture SHALL be bit-serial: one operand bit per clock, LSB first, with a single borrow flip-flop.
REQ-005 The FSM SHALL have three states: IDLE, COMPUTE and DONE.
REQ-006 In IDLE or DONE, start=1 SHALL capture a, b and rin into internal shift registers and the borrow flip-flop, clear the 3-bit bit counter, and go to COMPUTE.
REQ-007 In IDLE or DONE, start=0 SHALL lead to IDLE.
REQ-008 In COMPUTE, each edge SHALL compute d = ai ^ bi ^ br and br_next = (~ai & bi) | (~(ai ^ bi) & br).
REQ-009 In COMPUTE, each edge SHALL also shift d into the result register from the MSB side and increment the counter.
REQ-010 After the edge that processes bit 7, the FSM SHALL enter DONE.
REQ-011 On entry to DONE:
- s SHALL be updated with the full 8-bit difference.
- rout SHALL be updated with the final borrow.
- ovf SHALL be updated with (a7 != b7) & (s7 != a7), using the captured a and b.
REQ-012 Latency: with start sampled at edge E, done SHALL be high in the cycle after edge E+8.
REQ-013 busy SHALL be high for exactly the 8 cycles following edge E.
REQ-014 done SHALL be high only in DONE, for exactly one cycle per accepted start.
REQ-015 s, rout and ovf SHALL change only on entry to DONE or on reset, and SHALL hold their values through IDLE and any subsequent COMPUTE.
REQ-016 start asserted during COMPUTE SHALL be ignored; changes to a, b and rin during COMPUTE SHALL not affect the result.
REQ-017 start=1 in the DONE cycle SHALL be accepted, allowing back-to-back operations every 9 cycles.
REQ-018 Boundary results SHALL be:
- a=b with rin=0: s=0, rout=0.
- a=0, b=0, rin=1: s=255, rout=1.
- a=0, b=255, rin=1: s=0, rout=1 (wrap-around).

Reset
REQ-019 While rst=1 at a rising edge, the FSM SHALL go to IDLE, and s, rout, ovf, busy, done and the counter SHALL be 0; rst SHALL take priority over start.
REQ-020 rst asserted mid-COMPUTE SHALL abort the operation with no done pulse, and the outputs SHALL read 0.
REQ-021 The first start after rst deasserts SHALL behave exactly as after power-up reset.

Verification
REQ-022 a=201, b=12, rin=0, one start pulse -> after 9 cycles: done=1, s=189, rout=0, ovf=0; busy high for 8 cycles.
REQ-023 a=201, b=75, rin=0 -> s=126, rout=0, ovf=1; then a=12, b=201, rin=0 -> s=67, rout=1, ovf=0.
REQ-024 a=0, b=0, rin=1 -> s=255, rout=1, ovf=0; a=128, b=1, rin=0 -> s=127, rout=0, ovf=1.
REQ-025 Back-to-back runs:
- start held high continuously with a=100, b=50 -> done pulses every 9 cycles, s=50 each time.
- operand changes and start pulses during busy -> no effect on the result.
REQ-026 Reset mid-operation: rst asserted 4 cycles after start -> next cycle busy=0, done=0, s=0, rout=0, ovf=0, with no done pulse; a new start then completes correctly.
REQ-027 A randomized bench SHALL run 1000 operations and compare s, rout and ovf against (a - b - rin) computed at 9-bit width.
